// File: rtl/cdc_pkg.sv
// Shared types for the req/ack clock-domain-crossing endpoints:
// signalling mode selector and per-channel handshake FSM states.
package cdc_pkg;

  typedef enum logic {
    HS_4PHASE,
    HS_2PHASE
  } hs_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE,
    WAIT
  } hs_state_e;

endpackage

// File: rtl/cdc_sync.sv
// One-bit synchroniser flop chain, async active-low reset to 0.
// Ports: clk, rst_n, d (async input), q (synchronised output).
module cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Multi-channel req/ack CDC sending endpoint (source clock domain).
// Ports: clk, rst_n, in_valid/in_ready/in_data (local side),
// req_o/data_o/ack_i (remote side), err/err_clr (ack watchdog).
// Optional watchdog built when CDC_HS_TX_TIMEOUT_EN is defined.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int       NCH         = 4,
  parameter int       W           = 128,
  parameter int       SYNC_STAGES = 2,
  parameter hs_mode_e MODE        = HS_4PHASE,
  parameter int       TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  input  logic [NCH-1:0][W-1:0] in_data,
  output logic [NCH-1:0]        req_o,
  input  logic [NCH-1:0]        ack_i,
  output logic [NCH-1:0][W-1:0] data_o,
  output logic [NCH-1:0]        err,
  input  logic [NCH-1:0]        err_clr
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch

    hs_state_e      st;
    hs_state_e      st_nxt;
    logic           ack_s;
    logic           rdy;
    logic           acc;
    logic           req;
    logic           req_nxt;
    logic [W-1:0]   data;

    cdc_sync #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ack_i[c]),
      .q     (ack_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nxt;
    end

    always_comb begin
      st_nxt = st;
      unique case (st)
        IDLE: begin
          if (in_valid[c])
            st_nxt = (MODE == HS_2PHASE) ? WAIT : REQ;
        end
        REQ:     if (ack_s)        st_nxt = RELEASE;
        RELEASE: if (!ack_s)       st_nxt = IDLE;
        WAIT:    if (ack_s == req) st_nxt = IDLE;
        default:                   st_nxt = IDLE;
      endcase
    end

    // req is a flop so the remote side never sees a glitch
    always_comb begin
      rdy     = (st == IDLE);
      acc     = rdy && in_valid[c];
      req_nxt = req;
      if (acc)
        req_nxt = (MODE == HS_2PHASE) ? ~req : 1'b1;
      else if (MODE == HS_4PHASE && st == REQ && ack_s)
        req_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        req  <= 1'b0;
        data <= '0;
      end else begin
        req <= req_nxt;
        if (acc) data <= in_data[c];
      end
    end

    assign in_ready[c] = rdy;
    assign req_o[c]    = req;
    assign data_o[c]   = data;

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt;
    logic          er;

    // counter saturates at TIMEOUT; a clear restarts it,
    // but a coincident set takes priority over the clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        er  <= 1'b0;
      end else if (st == IDLE) begin
        cnt <= '0;
        if (err_clr[c]) er <= 1'b0;
      end else if (cnt == TW'(TIMEOUT - 1)) begin
        cnt <= TW'(TIMEOUT);
        er  <= 1'b1;
      end else if (err_clr[c]) begin
        cnt <= '0;
        er  <= 1'b0;
      end else if (cnt != TW'(TIMEOUT)) begin
        cnt <= cnt + TW'(1);
      end
    end

    assign err[c] = er;
`else
    assign err[c] = 1'b0;
`endif

  end

`ifndef CDC_HS_TX_TIMEOUT_EN
  logic unused_cfg;
  assign unused_cfg = (^err_clr) ^ (TIMEOUT > 0);
`endif

endmodule

// File: doc/cdc_hs_tx.md
# cdc_hs_tx

Multi-channel, parametrised sending endpoint for req/ack clock-domain crossings, living entirely in the source clock domain. Per channel it accepts a word on a local valid/ready port and holds it stable on `data_o`. It drives the request line toward the remote domain and synchronises the returning acknowledge through a configurable-depth flop chain. Either 4-phase (level) or 2-phase (toggle) signalling is selectable at elaboration, and an optional ack watchdog can be compiled in.

## Interface
- `NCH`, 4: number of independent channels (>=1).
- `W`, 128: data width per channel.
- `SYNC_STAGES`, 2: ack synchroniser depth (>=2).
- `MODE`, `cdc_pkg::HS_4PHASE`: `HS_4PHASE` or `HS_2PHASE`.
- `TIMEOUT`, 1024: watchdog limit in cycles (only used with the macro; >=1).

- `clk`  in  1  source-domain clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  NCH  per-channel word offered.
- `in_ready`  out  NCH  per-channel endpoint idle, word accepted on valid&&ready.
- `in_data`  in  NCH x W  per-channel word.
- `req_o`  out  NCH  request toward remote domain (registered, glitch-free).
- `ack_i`  in  NCH  acknowledge from remote domain (asynchronous to `clk`).
- `data_o`  out  NCH x W  held data toward remote domain (registered).
- `err`  out  NCH  sticky watchdog flag.
- `err_clr`  in  NCH  clears `err` bits.

## Operation
- Channels are fully independent, each with one FSM, one data register, one req flop and one `cdc_sync` instance producing `ack_s`.
- `in_ready[c]` = (state == IDLE). It is combinational from state only and never depends on `in_valid`.
- 4-phase FSM:
  - IDLE → REQ on accept: `data_o` ← `in_data`, `req_o` ← 1.
  - REQ → RELEASE when `ack_s`=1: `req_o` ← 0.
  - RELEASE → IDLE when `ack_s`=0.
- 2-phase FSM:
  - IDLE → WAIT on accept: `data_o` ← `in_data`, `req_o` ← ~`req_o`.
  - WAIT → IDLE when `ack_s` == `req_o`.
- `data_o` changes only on an accept edge and is held through the whole handshake.
- `ack_i` activity in IDLE has no effect, apart from feeding the synchroniser.

## Timing
- Reset values: state IDLE, `req_o`=0, `data_o`=0, synchroniser flops 0, `err`=0, so `in_ready`=all-ones.
- Reset is asynchronous assert and synchronous-to-`clk` deassert, which the block's driver guarantees. Reset mid-handshake aborts the transfer and returns `req_o` to 0 immediately.
- Accept at edge k: `req_o` and `data_o` update at edge k. `in_ready` is low from k until the FSM re-enters IDLE.
- `ack_s` lags `ack_i` by `SYNC_STAGES` edges.
- In 4-phase, with the remote acking instantly, the minimum turnaround between consecutive accepts is 2·`SYNC_STAGES`+2 cycles.
- In 2-phase, the minimum turnaround is `SYNC_STAGES`+1 cycles.
- Back-to-back valid is held off by `in_ready`. No word is dropped or duplicated.

## Configuration
- `CDC_HS_TX_TIMEOUT_EN` defined:
  - A per-channel counter of width $clog2(TIMEOUT+1) counts cycles spent outside IDLE and clears on entering IDLE.
  - On reaching `TIMEOUT`, `err[c]` is set and stays set until `err_clr[c]`. If clear and set coincide, set wins.
  - The FSM is not affected; it keeps waiting.
- Undefined: no counters are built, `err` is tied to 0 and `err_clr` is ignored.

## Structure
- `cdc_pkg`: `hs_mode_e` (`HS_4PHASE`, `HS_2PHASE`) and `hs_state_e` (IDLE, REQ, RELEASE, WAIT).
- Sub-module `cdc_sync`:
  - Parameter `STAGES`.
  - One-bit flop chain with async active-low reset to 0.
  - Instantiated once per channel via generate.

## Test plan
- Reset, 4-phase, `SYNC_STAGES`=2, ch0: accept 128'hA5 at edge 0 → `req_o[0]`=1 and `data_o[0]`=A5 at edge 0. Raise `ack_i` at cycle 3 → `req_o` falls at edge 6. Drop `ack_i` at cycle 8 → `in_ready[0]` high after edge 11.
- 2-phase, two words 1 then 2: `req_o` goes 0→1 then 1→0. Each word is accepted only after `ack_i` matches `req_o` plus 2 sync edges. `data_o` is never changed while `in_ready`=0.
- All 4 channels active, with ack delays of 1, 5, 9 and 0 cycles on ch0–ch3 → each channel completes independently, with no cross-channel `in_ready` coupling.
- Assert `rst_n` low while in REQ with `ack_i`=1 → `req_o`=0, `data_o`=0 and `in_ready`=1 asynchronously. After release, the first accept behaves as a fresh transfer.
- Macro on, `TIMEOUT`=16, ack never returns → `err[0]` rises on cycle 16 after the accept. Pulse `err_clr[0]` → `err[0]` clears, then sets again 16 cycles after the counter restarts only if still outside IDLE. Macro off → `err`=0 throughout.
- Toggle `ack_i` on ch1 while it is IDLE → no state change and `req_o[1]` stays 0.
